// File: rtl/mmu_pxr_bridge_pkg.sv
// mmu_defs: shared definitions for the MMU register-port bridge.
//   - 22-bit physical byte addresses of the PDR/PAR banks and SR0-SR3
//     (octal values are given alongside the hex constants)
//   - processor mode codes used in the upper bits of the register index
//   - register index codes for SR0-SR3
//   - bridge FSM state encoding
package mmu_defs;

    // Bank bases cover 64 bytes each (32 word registers: PDR0-7, PAR0-7 and
    // their alternate halves). SR addresses name a single word.
    localparam logic [21:0] PA_KERNEL = 22'h3FF4C0;   // 17772300
    localparam logic [21:0] PA_SUPER  = 22'h3FF480;   // 17772200
    localparam logic [21:0] PA_USER   = 22'h3FFF80;   // 17777600
    localparam logic [21:0] PA_SR0    = 22'h3FFF7A;   // 17777572
    localparam logic [21:0] PA_SR1    = 22'h3FFF7C;   // 17777574
    localparam logic [21:0] PA_SR2    = 22'h3FFF7E;   // 17777576
    localparam logic [21:0] PA_SR3    = 22'h3FF54E;   // 17772516

    localparam logic [1:0] MODE_KERNEL = 2'b00;
    localparam logic [1:0] MODE_SUPER  = 2'b01;
    localparam logic [1:0] MODE_USER   = 2'b11;

    localparam logic [7:0] IDX_SR0 = 8'h80;
    localparam logic [7:0] IDX_SR1 = 8'h81;
    localparam logic [7:0] IDX_SR2 = 8'h82;
    localparam logic [7:0] IDX_SR3 = 8'h83;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_WAIT   = 3'd2,
        S_ACK    = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/mmu_pxr_bridge_if.sv
// mmu_pxr_bridge_if: bus-side request/response signals plus the PXR port
// toward the MMU.
//   slave  modport : the bridge (takes bus requests, drives the PXR port)
//   master modport : the environment (CPU bus side and MMU model)
// Handshake: bus_rd/bus_wr are levels held by the initiator until bus_ack;
// bus_ack is a one-cycle pulse; the initiator must drop its request before
// the bridge accepts another one. pxr_rd/pxr_wr are one-cycle strobes and
// pxr_data_in must be valid the cycle after pxr_rd.
interface mmu_pxr_bridge_if;
    logic [21:0] bus_pa;
    logic        bus_rd;
    logic        bus_wr;
    logic [1:0]  bus_be;
    logic [15:0] bus_data_in;
    logic        bus_hit;
    logic        bus_ack;
    logic [15:0] bus_data_out;
    logic        pxr_rd;
    logic        pxr_wr;
    logic [1:0]  pxr_be;
    logic [7:0]  pxr_addr;
    logic [15:0] pxr_data_out;
    logic [15:0] pxr_data_in;

    modport slave (
        input  bus_pa, bus_rd, bus_wr, bus_be, bus_data_in, pxr_data_in,
        output bus_hit, bus_ack, bus_data_out,
               pxr_rd, pxr_wr, pxr_be, pxr_addr, pxr_data_out
    );

    modport master (
        output bus_pa, bus_rd, bus_wr, bus_be, bus_data_in, pxr_data_in,
        input  bus_hit, bus_ack, bus_data_out,
               pxr_rd, pxr_wr, pxr_be, pxr_addr, pxr_data_out
    );
endinterface

// File: rtl/mmu_pxr_bridge_decode.sv
// mmu_reg_decode: combinational I/O-page decode of a physical byte address
// into an MMU register index.
//   pa   in  22  physical byte address (bit 0 ignored)
//   hit  out 1   address names an MMU register
//   addr out 8   register index {0, mode[1:0], idx[4:0]} or 8'h80-8'h83
// Build option: MMU_SR3_EN makes SR3 (17772516) claimable; without it the
// address is left unclaimed so the bus times out.
module mmu_reg_decode
    import mmu_defs::*;
(
    input  logic [21:0] pa,
    output logic        hit,
    output logic [7:0]  addr
);

    // Byte lane selection comes from the byte enables, never from pa[0].
    logic unused_pa0;
    assign unused_pa0 = pa[0];

    always_comb begin
        hit  = 1'b0;
        addr = 8'h00;
        if (pa[21:6] == PA_KERNEL[21:6]) begin
            hit  = 1'b1;
            addr = {1'b0, MODE_KERNEL, pa[5:1]};
        end else if (pa[21:6] == PA_SUPER[21:6]) begin
            hit  = 1'b1;
            addr = {1'b0, MODE_SUPER, pa[5:1]};
        end else if (pa[21:6] == PA_USER[21:6]) begin
            hit  = 1'b1;
            addr = {1'b0, MODE_USER, pa[5:1]};
        end else if (pa[21:1] == PA_SR0[21:1]) begin
            hit  = 1'b1;
            addr = IDX_SR0;
        end else if (pa[21:1] == PA_SR1[21:1]) begin
            hit  = 1'b1;
            addr = IDX_SR1;
        end else if (pa[21:1] == PA_SR2[21:1]) begin
            hit  = 1'b1;
            addr = IDX_SR2;
        end
`ifdef MMU_SR3_EN
        else if (pa[21:1] == PA_SR3[21:1]) begin
            hit  = 1'b1;
            addr = IDX_SR3;
        end
`endif
    end

endmodule

// File: rtl/mmu_pxr_bridge.sv
// mmu_pxr_bridge: turns a held CPU bus cycle aimed at an MMU register into a
// single pxr_rd/pxr_wr strobe and returns data plus a one-cycle bus_ack.
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   bus        slave modport of mmu_pxr_bridge_if (bus and PXR signals)
//   state_dbg  out  current FSM state
// Sequence: IDLE -> STROBE -> WAIT -> ACK -> HOLD -> IDLE. Strobe one cycle
// after the request is accepted, ack three cycles after. HOLD waits for the
// request to drop so a held request produces exactly one access.
// Build option: MMU_SR3_EN (handled in mmu_reg_decode).
module mmu_pxr_bridge
    import mmu_defs::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    mmu_pxr_bridge_if.slave        bus,
    output state_t                 state_dbg
);

    state_t      state, state_nx;
    logic        latch, capture;
    logic        dec_hit;
    logic [7:0]  dec_addr;

    logic        op_wr;
    logic        pxr_rd_q, pxr_wr_q, ack_q;
    logic [7:0]  addr_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q, rdata_q;

    mmu_reg_decode u_decode (
        .pa   (bus.bus_pa),
        .hit  (dec_hit),
        .addr (dec_addr)
    );

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((bus.bus_rd | bus.bus_wr) & dec_hit) begin
                    state_nx = S_STROBE;
                    latch    = 1'b1;
                end
            end
            S_STROBE: state_nx = S_WAIT;
            S_WAIT: begin
                state_nx = S_ACK;
                capture  = ~op_wr;
            end
            S_ACK:    state_nx = S_HOLD;
            S_HOLD: begin
                if (!bus.bus_rd && !bus.bus_wr)
                    state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Strobes and ack are flops set one cycle ahead so they leave the block
    // glitch-free; reset clears them immediately, truncating any in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            pxr_rd_q <= 1'b0;
            pxr_wr_q <= 1'b0;
            ack_q    <= 1'b0;
            addr_q   <= 8'h00;
            be_q     <= 2'b00;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
        end else begin
            state    <= state_nx;
            // rd and wr together count as a write
            pxr_rd_q <= latch & ~bus.bus_wr;
            pxr_wr_q <= latch & bus.bus_wr;
            ack_q    <= (state == S_WAIT);
            if (latch) begin
                op_wr   <= bus.bus_wr;
                addr_q  <= dec_addr;
                be_q    <= bus.bus_be;
                wdata_q <= bus.bus_data_in;
            end
            if (capture)
                rdata_q <= bus.pxr_data_in;
        end
    end

    assign bus.bus_hit      = dec_hit;
    assign bus.bus_ack      = ack_q;
    assign bus.bus_data_out = rdata_q;
    assign bus.pxr_rd       = pxr_rd_q;
    assign bus.pxr_wr       = pxr_wr_q;
    assign bus.pxr_be       = be_q;
    assign bus.pxr_addr     = addr_q;
    assign bus.pxr_data_out = wdata_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_mmu_pxr_bridge.sv
// Testbench for mmu_pxr_bridge: directed accesses from the register map,
// randomized accesses against a register-file reference model, held
// requests, non-hit addresses and reset in the middle of a strobe.
module tb_mmu_pxr_bridge;
    import mmu_defs::*;

    logic   clk;
    logic   reset_n;
    state_t state_dbg;

    mmu_pxr_bridge_if bus_if ();

    mmu_pxr_bridge dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- MMU model (environment) ----------------
    logic [15:0] mmu_mem [256];
    always @(posedge clk) begin
        if (bus_if.pxr_rd)
            bus_if.pxr_data_in <= mmu_mem[bus_if.pxr_addr];
        if (bus_if.pxr_wr) begin
            if (bus_if.pxr_be[0]) mmu_mem[bus_if.pxr_addr][7:0]  <= bus_if.pxr_data_out[7:0];
            if (bus_if.pxr_be[1]) mmu_mem[bus_if.pxr_addr][15:8] <= bus_if.pxr_data_out[15:8];
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [256];
    logic [15:0] exp_last_rd;

    // Register map written as address arithmetic: each bank is 32 words,
    // index = mode*32 + word offset; SRs are single words at 0x80+n.
    function automatic void ref_decode(input logic [21:0] pa, output bit hit, output logic [7:0] a);
        int p;
        p   = int'(pa);
        hit = 1'b0;
        a   = 8'h00;
        if (p >= 'h3FF4C0 && p < 'h3FF4C0 + 64) begin
            hit = 1'b1; a = 8'((p - 'h3FF4C0) / 2);
        end else if (p >= 'h3FF480 && p < 'h3FF480 + 64) begin
            hit = 1'b1; a = 8'(32 + (p - 'h3FF480) / 2);
        end else if (p >= 'h3FFF80 && p < 'h3FFF80 + 64) begin
            hit = 1'b1; a = 8'(96 + (p - 'h3FFF80) / 2);
        end else if (p / 2 >= 'h3FFF7A / 2 && p / 2 <= 'h3FFF7E / 2) begin
            hit = 1'b1; a = 8'(128 + (p / 2 - 'h3FFF7A / 2));
        end
`ifdef MMU_SR3_EN
        else if (p / 2 == 'h3FF54E / 2) begin
            hit = 1'b1; a = 8'd131;
        end
`endif
    endfunction

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver / monitor ----------------
    logic        r_hit;
    int          r_nrd, r_nwr, r_scyc, r_nack, r_acyc;
    logic [7:0]  r_addr;
    logic [1:0]  r_be;
    logic [15:0] r_wdata, r_adata;

    // Starts at posedge+1. Request is driven in cycle 0 and held for
    // 'hold' cycles; a fixed 12-cycle window is observed on negedges.
    task automatic run_access(input logic [21:0] pa, input logic rd, input logic wr,
                              input logic [1:0] be, input logic [15:0] wdata, input int hold);
        bus_if.bus_pa      = pa;
        bus_if.bus_rd      = rd;
        bus_if.bus_wr      = wr;
        bus_if.bus_be      = be;
        bus_if.bus_data_in = wdata;
        r_hit = 1'b0; r_nrd = 0; r_nwr = 0; r_scyc = -1; r_nack = 0; r_acyc = -1;
        r_addr = 8'h00; r_be = 2'b00; r_wdata = 16'h0; r_adata = 16'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (cyc == 0) r_hit = bus_if.bus_hit;
            if (bus_if.pxr_rd || bus_if.pxr_wr) begin
                if (bus_if.pxr_rd) r_nrd++;
                if (bus_if.pxr_wr) r_nwr++;
                r_scyc  = cyc;
                r_addr  = bus_if.pxr_addr;
                r_be    = bus_if.pxr_be;
                r_wdata = bus_if.pxr_data_out;
            end
            if (bus_if.bus_ack) begin
                r_nack++;
                r_acyc  = cyc;
                r_adata = bus_if.bus_data_out;
            end
            @(posedge clk);
            #1;
            if (cyc + 1 == hold) begin
                bus_if.bus_rd = 1'b0;
                bus_if.bus_wr = 1'b0;
            end
        end
    endtask

    task automatic check_access(input string tag, input logic [21:0] pa, input logic rd,
                                input logic wr, input logic [1:0] be, input logic [15:0] wdata,
                                input int hold);
        bit         e_hit;
        logic [7:0] e_addr;
        ref_decode(pa, e_hit, e_addr);
        run_access(pa, rd, wr, be, wdata, hold);
        chk({tag, ".hit"}, 32'(r_hit), 32'(e_hit));
        if (e_hit) begin
            chk({tag, ".n_rd"}, r_nrd, wr ? 0 : 1);
            chk({tag, ".n_wr"}, r_nwr, wr ? 1 : 0);
            chk({tag, ".strobe_cyc"}, r_scyc, 1);
            chk({tag, ".addr"}, 32'(r_addr), 32'(e_addr));
            chk({tag, ".be"}, 32'(r_be), 32'(be));
            chk({tag, ".n_ack"}, r_nack, 1);
            chk({tag, ".ack_cyc"}, r_acyc, 3);
            if (wr) begin
                chk({tag, ".wdata"}, 32'(r_wdata), 32'(wdata));
                if (be[0]) ref_mem[e_addr][7:0]  = wdata[7:0];
                if (be[1]) ref_mem[e_addr][15:8] = wdata[15:8];
            end else begin
                chk({tag, ".rdata"}, 32'(r_adata), 32'(ref_mem[e_addr]));
                exp_last_rd = ref_mem[e_addr];
            end
        end else begin
            chk({tag, ".n_strobe"}, r_nrd + r_nwr, 0);
            chk({tag, ".n_ack"}, r_nack, 0);
        end
        chk({tag, ".data_out_held"}, 32'(bus_if.bus_data_out), 32'(exp_last_rd));
        chk({tag, ".idle"}, 32'(state_dbg), 32'(S_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] v;
        logic [21:0] pa;
        int          region, sel;

        reset_n            = 1'b0;
        bus_if.bus_pa      = 22'h0;
        bus_if.bus_rd      = 1'b0;
        bus_if.bus_wr      = 1'b0;
        bus_if.bus_be      = 2'b00;
        bus_if.bus_data_in = 16'h0;
        bus_if.pxr_data_in = 16'h0;
        exp_last_rd        = 16'h0;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            mmu_mem[i] = v;
            ref_mem[i] = v;
        end
        mmu_mem[8'h10] = 16'o001600;
        ref_mem[8'h10] = 16'o001600;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ack",      32'(bus_if.bus_ack),      0);
        chk("rst.pxr_rd",   32'(bus_if.pxr_rd),       0);
        chk("rst.pxr_wr",   32'(bus_if.pxr_wr),       0);
        chk("rst.addr",     32'(bus_if.pxr_addr),     0);
        chk("rst.be",       32'(bus_if.pxr_be),       0);
        chk("rst.wdata",    32'(bus_if.pxr_data_out), 0);
        chk("rst.rdata",    32'(bus_if.bus_data_out), 0);
        chk("rst.state",    32'(state_dbg),           32'(S_IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        check_access("kpar0_rd",   22'h3FF4E0, 1'b1, 1'b0, 2'b11, 16'h0000, 4);
        chk("kpar0_rd.addr_hex", 32'(r_addr), 32'h10);
        chk("kpar0_rd.data_oct", 32'(r_adata), 32'(16'o001600));
        check_access("updr7_wrb",  22'h3FFF8F, 1'b0, 1'b1, 2'b10, 16'h7F00, 4);
        chk("updr7_wrb.addr_hex", 32'(r_addr), 32'h67);
        check_access("sr0_held",   22'h3FFF7A, 1'b1, 1'b0, 2'b11, 16'h0000, 10);
        chk("sr0_held.addr_hex", 32'(r_addr), 32'h80);
        check_access("sr0_again",  22'h3FFF7B, 1'b1, 1'b0, 2'b11, 16'h0000, 4);
        check_access("nonhit",     22'h3FFF70, 1'b1, 1'b0, 2'b11, 16'h0000, 4);
        check_access("sr3",        22'h3FF54E, 1'b1, 1'b0, 2'b11, 16'h0000, 4);
        check_access("spdr0_rdwr", 22'h3FF480, 1'b1, 1'b1, 2'b11, 16'hA5C3, 4);
        chk("spdr0_rdwr.addr_hex", 32'(r_addr), 32'h20);
        check_access("withdrawn",  22'h3FF4C2, 1'b0, 1'b1, 2'b01, 16'h1234, 1);
        check_access("sr2_rd",     22'h3FFF7E, 1'b1, 1'b0, 2'b11, 16'h0000, 4);

        // randomized accesses
        for (int n = 0; n < 50; n++) begin
            region = $urandom_range(0, 5);
            case (region)
                0: pa = 22'h3FF4C0 + 22'($urandom_range(0, 63));
                1: pa = 22'h3FF480 + 22'($urandom_range(0, 63));
                2: pa = 22'h3FFF80 + 22'($urandom_range(0, 63));
                3: pa = 22'h3FFF7A + 22'($urandom_range(0, 5));
                4: pa = 22'h3FF54E + 22'($urandom_range(0, 1));
                default: pa = 22'h3FE000 + 22'($urandom_range(0, 8191));
            endcase
            sel = $urandom_range(0, 2);
            check_access($sformatf("rnd%0d", n), pa, sel != 1, sel != 0,
                         2'($urandom_range(1, 3)), 16'($urandom), $urandom_range(1, 10));
        end

        // reset during STROBE of a write to kernel PDR3
        bus_if.bus_pa      = 22'h3FF4C6;
        bus_if.bus_wr      = 1'b1;
        bus_if.bus_rd      = 1'b0;
        bus_if.bus_be      = 2'b11;
        bus_if.bus_data_in = 16'hBEEF;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid.strobe_before", 32'(bus_if.pxr_wr), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid.pxr_wr", 32'(bus_if.pxr_wr),       0);
        chk("rst_mid.ack",    32'(bus_if.bus_ack),      0);
        chk("rst_mid.addr",   32'(bus_if.pxr_addr),     0);
        chk("rst_mid.wdata",  32'(bus_if.pxr_data_out), 0);
        chk("rst_mid.rdata",  32'(bus_if.bus_data_out), 0);
        chk("rst_mid.state",  32'(state_dbg),           32'(S_IDLE));
        exp_last_rd   = 16'h0;
        bus_if.bus_wr = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_access("post_rst_rd", 22'h3FF4E0, 1'b1, 1'b0, 2'b11, 16'h0000, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmu_pxr_bridge.md
# mmu_pxr_bridge

Unibus-side initiator for the MMU register (PXR) port. Decodes CPU I/O-page physical bus cycles that target PDP-11 memory-management registers (PDR/PAR banks, SR0–SR2, optionally SR3). Converts each into a single-cycle pxr_rd/pxr_wr strobe toward whichever MMU is instantiated, null or full. Returns read data and an acknowledge to the bus. It sits between the I/O-page address decoder and the MMU.

## Interface
- No parameters.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- bus_pa  in  22  physical byte address of current bus cycle.
- bus_rd  in  1  read request; held until bus_ack.
- bus_wr  in  1  write request; held until bus_ack.
- bus_be  in  2  byte enables (bit0 = low byte).
- bus_data_in  in  16  write data.
- bus_hit  out  1  combinational: bus_pa decodes to an MMU register.
- bus_ack  out  1  one-cycle transfer-complete pulse.
- bus_data_out  out  16  read data, valid while bus_ack=1 and held until next read capture.
- pxr_rd  out  1  one-cycle read strobe to MMU.
- pxr_wr  out  1  one-cycle write strobe to MMU.
- pxr_be  out  2  byte enables, copy of bus_be latched at request.
- pxr_addr  out  8  register index.
- pxr_data_out  out  16  write data to MMU, latched at request.
- pxr_data_in  in  16  read data from MMU, valid the cycle after pxr_rd.

## Operation
- Decode (octal PA; idx = bus_pa[5:1]):
  - 17772300–17772377 kernel -> pxr_addr = {1'b0, 2'b00, idx}.
  - 17772200–17772277 supervisor -> {1'b0, 2'b01, idx}.
  - 17777600–17777677 user -> {1'b0, 2'b11, idx}.
  - SR0 17777572 -> 8'h80; SR1 17777574 -> 8'h81; SR2 17777576 -> 8'h82; SR3 17772516 -> 8'h83 (see Configuration).
  - bus_pa[0] is ignored; byte selection uses bus_be only.
- FSM states:
  - IDLE: on (bus_rd|bus_wr) & bus_hit, latch pxr_addr, pxr_be and write data; go to STROBE.
  - STROBE: assert exactly one of pxr_wr or pxr_rd; go to WAIT.
  - WAIT: on a read, capture pxr_data_in into bus_data_out; go to ACK.
  - ACK: bus_ack=1; go to HOLD.
  - HOLD: remain until bus_rd=bus_wr=0, then go to IDLE. This blocks retrigger on a held request.
- bus_rd & bus_wr together: treated as a write.
- Non-hit requests: ignored; no strobe, no ack. Another slave or the bus timeout owns the cycle.
- Request withdrawn after IDLE: the sequence still completes, including the strobe and the ack pulse. The MMU side stays consistent.
- Request signals are not re-sampled mid-sequence. Latched address and data govern the access.

## Timing
- Reset values: state IDLE; bus_ack, pxr_rd, pxr_wr = 0; pxr_addr = 8'h00; pxr_be = 2'b00; pxr_data_out = 16'h0000; bus_data_out = 16'h0000. bus_hit is combinational.
- Request sampled at edge k. Strobe is high during cycle k+1. Read data is captured at edge k+3. bus_ack is high during cycle k+3. Latency is 3 cycles.
- Strobes are registered outputs and exactly one cycle wide. There is at most one access per bus request.
- Minimum spacing between accesses is 5 cycles: request deassert must be seen in HOLD before IDLE.
- Reset asserted mid-sequence: all outputs return immediately to reset values. An in-flight strobe is truncated, no ack is issued, and a half-done write is acceptable.
- Writes do not modify bus_data_out.

## Configuration
- MMU_SR3_EN defined: 17772516 decodes to pxr_addr 8'h83 and asserts bus_hit.
- MMU_SR3_EN undefined: 17772516 is not claimed (bus_hit=0) and no access is generated, so the bus times out as on an 11/40-class machine.

## Structure
- Shared include or package `mmu_defs`:
  - octal base addresses for kernel, supervisor, user, SR0–SR3;
  - mode codes 00/01/11;
  - SR index codes 8'h80–8'h83;
  - FSM state encodings.
- One sub-module, `mmu_reg_decode`: combinational bus_pa -> {hit, pxr_addr}, holding the MMU_SR3_EN conditional. The FSM lives in mmu_pxr_bridge.

## Test plan
- Read kernel PAR0: bus_pa=17772340, bus_rd=1, MMU returns 16'o001600 -> pxr_rd in cycle 1 with pxr_addr=8'h10. bus_ack in cycle 3 with bus_data_out=16'o001600.
- User PDR7 byte write: bus_pa=17777617, bus_be=2'b10, data 16'h7F00 -> one pxr_wr, pxr_addr=8'h67, pxr_be=2'b10, pxr_data_out=16'h7F00. bus_ack in cycle 3.
- Held request: bus_rd stays high for 10 cycles on SR0 (8'h80) -> exactly one pxr_rd and one bus_ack. The next access starts only after bus_rd drops.
- Non-hit: bus_pa=17777560 read -> bus_hit=0, no strobes, no ack. SR3 at 17772516 -> hit and 8'h83 with MMU_SR3_EN, no hit without it.
- Reset during STROBE: reset_n low -> pxr_wr and bus_ack drop immediately. After release, the FSM is IDLE, and a new request completes normally in 3 cycles.
- Simultaneous bus_rd and bus_wr on supervisor PDR0 (17772200) -> pxr_wr only, pxr_addr=8'h20, bus_data_out unchanged.
